// File: rtl/lsmitll_jtl_pulse_monitor.sv
// Pulse monitor for a toggle-encoded LSmitll JTL output. It turns each level change into a
// one-cycle strobe, counts pulses, times the gaps between them and queues those gaps in a FIFO.
module lsmitll_jtl_pulse_monitor #(
    parameter int CW      = 16,
    parameter int IW      = 12,
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          q_in,
    input  logic          clr_err,
    input  logic          iv_ready,
    output logic          pulse,
    output logic [CW-1:0] pulse_count,
    output logic          iv_valid,
    output logic [IW-1:0] iv_data,
    output logic          err_spacing,
    output logic          err_overflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] SETTLE = 2'd0;
    localparam logic [1:0] IDLE   = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic [IW-1:0] GAP_MAX   = '1;
    localparam logic [IW-1:0] MIN_GAP_V = IW'(MIN_GAP);

    logic          s1, s2, s3;
    logic          tog;
    logic [1:0]    state;
    logic [1:0]    settle_cnt;
    logic [IW-1:0] gap;

    logic [IW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full;
    logic          push_req, push, pop, drop, short_gap;

    // s1 is the metastability catcher; the edge is taken between the two settled stages.
    assign tog = s2 ^ s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= q_in;
            s2 <= q_in;
            s3 <= q_in;
        end else begin
            s1 <= q_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse       <= 1'b0;
            pulse_count <= '0;
        end else begin
            pulse <= tog & (state != SETTLE);
            if (pulse)
                pulse_count <= pulse_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            gap        <= '0;
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt == 2'd2)
                        state <= IDLE;
                    else
                        settle_cnt <= settle_cnt + 2'd1;
                end
                IDLE: begin
                    if (pulse) begin
                        state <= RUN;
                        gap   <= IW'(1);
                    end
                end
                RUN: begin
                    if (pulse)
                        gap <= IW'(1);
                    else if (gap != GAP_MAX)
                        gap <= gap + 1'b1;
                end
                default: state <= SETTLE;
            endcase
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req  = pulse && (state == RUN);
    assign pop       = !empty && iv_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign short_gap = push_req && (gap < MIN_GAP_V);

    assign iv_valid = !empty;
    assign iv_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= gap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_spacing  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_spacing  <= short_gap | (err_spacing & ~clr_err);
            err_overflow <= drop | (err_overflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_lsmitll_jtl_pulse_monitor.sv
// Directed bench for the JTL pulse monitor: cycle n is the interval after the n-th rising edge
// following the reset edge; inputs are driven and outputs sampled 1 time unit after each edge.
module tb_lsmitll_jtl_pulse_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        q_in = 1'b0;
    logic        clr_err = 1'b0;
    logic        iv_ready = 1'b0;
    logic        pulse;
    logic [15:0] pulse_count;
    logic        iv_valid;
    logic [11:0] iv_data;
    logic        err_spacing;
    logic        err_overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    lsmitll_jtl_pulse_monitor #(.CW(16), .IW(12), .DEPTH(4), .MIN_GAP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .q_in         (q_in),
        .clr_err      (clr_err),
        .iv_ready     (iv_ready),
        .pulse        (pulse),
        .pulse_count  (pulse_count),
        .iv_valid     (iv_valid),
        .iv_data      (iv_data),
        .err_spacing  (err_spacing),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // One reset edge; afterwards we are in cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic toggle_at(input int n);
        run_to(n);
        q_in = ~q_in;
    endtask

    initial begin
        logic seen;
        #1;

        // 1: q_in held high through and after reset -> nothing happens
        q_in = 1'b1;
        tick();
        do_reset();
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= pulse;
        end
        chk("t1_no_pulse", seen, 0);
        chk("t1_count", pulse_count, 0);
        chk("t1_valid", iv_valid, 0);

        // 2: toggles at 10 and 30 -> pulses at 13 and 33, interval 20
        q_in = 1'b0;
        do_reset();
        chk("t2_rst_valid", iv_valid, 0);
        chk("t2_rst_data", iv_data, 0);
        toggle_at(10);
        run_to(12);
        chk("t2_pulse12", pulse, 0);
        run_to(13);
        chk("t2_pulse13", pulse, 1);
        run_to(14);
        chk("t2_pulse14", pulse, 0);
        toggle_at(30);
        run_to(33);
        chk("t2_pulse33", pulse, 1);
        run_to(34);
        chk("t2_count", pulse_count, 2);
        chk("t2_valid", iv_valid, 1);
        chk("t2_data", iv_data, 20);
        chk("t2_spacing", err_spacing, 0);

        // 3: spacing violation, clear, and set-wins-over-clear
        q_in = 1'b0;
        do_reset();
        toggle_at(10);
        toggle_at(12);
        toggle_at(14);
        run_to(15);
        chk("t3_spacing_pre", err_spacing, 0);
        run_to(16);
        chk("t3_data", iv_data, 2);
        chk("t3_spacing_set", err_spacing, 1);
        clr_err = 1'b1;
        run_to(17);
        chk("t3_spacing_clr", err_spacing, 0);
        run_to(18);
        chk("t3_set_wins", err_spacing, 1);
        clr_err = 1'b0;
        chk("t3_valid", iv_valid, 1);
        clr_err = 1'b1;
        run_to(19);
        clr_err = 1'b0;
        chk("t3_spacing_clr2", err_spacing, 0);

        // 4: overflow with no consumer, then drain
        q_in = 1'b0;
        do_reset();
        for (int i = 1; i <= 6; i++) toggle_at(i * 10);
        run_to(63);
        chk("t4_ovf_pre", err_overflow, 0);
        run_to(65);
        chk("t4_count", pulse_count, 6);
        chk("t4_ovf", err_overflow, 1);
        chk("t4_spacing", err_spacing, 0);
        iv_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_valid", iv_valid, 1);
            chk("t4_drain_data", iv_data, 10);
            tick();
        end
        iv_ready = 1'b0;
        chk("t4_empty_valid", iv_valid, 0);
        chk("t4_empty_data", iv_data, 0);
        chk("t4_ovf_sticky", err_overflow, 1);

        // 5: full FIFO, push and pop together; gap == MIN_GAP is legal
        q_in = 1'b0;
        do_reset();
        toggle_at(10);
        toggle_at(14);
        toggle_at(20);
        toggle_at(27);
        toggle_at(35);
        toggle_at(44);
        run_to(40);
        chk("t5_full_head", iv_data, 4);
        run_to(47);
        chk("t5_pulse47", pulse, 1);
        iv_ready = 1'b1;
        run_to(48);
        iv_ready = 1'b0;
        chk("t5_ovf", err_overflow, 0);
        chk("t5_spacing_eq", err_spacing, 0);
        iv_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain", iv_data, 6 + i);
            tick();
        end
        iv_ready = 1'b0;
        chk("t5_empty", iv_valid, 0);

        // 6: reset mid-operation clears everything and masks an early toggle
        q_in = 1'b0;
        do_reset();
        iv_ready = 1'b1;
        for (int i = 1; i <= 7; i++) toggle_at(i * 10);
        run_to(60);
        iv_ready = 1'b0;
        run_to(75);
        chk("t6_count_pre", pulse_count, 7);
        chk("t6_valid_pre", iv_valid, 1);
        chk("t6_data_pre", iv_data, 10);
        do_reset();
        chk("t6_rst_pulse", pulse, 0);
        chk("t6_rst_count", pulse_count, 0);
        chk("t6_rst_valid", iv_valid, 0);
        chk("t6_rst_data", iv_data, 0);
        chk("t6_rst_esp", err_spacing, 0);
        chk("t6_rst_eov", err_overflow, 0);
        q_in = ~q_in;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= pulse;
        end
        chk("t6_masked", seen, 0);
        chk("t6_count_post", pulse_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
